// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: one outstanding DRAM block read, per-set round-robin victim.
// Optional ICACHE_REFILL_PERF_EN adds saturating miss/drop counters as extra output ports.
module icache_refill_ctrl #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int BLOCK_SIZE = 64,
    parameter  int NUM_SETS   = 64,
    parameter  int NUM_WAYS   = 2,
    localparam int OFFSET_W   = $clog2(BLOCK_SIZE / 8),
    localparam int SET_W      = $clog2(NUM_SETS),
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int TAG_W      = ADDR_WIDTH - SET_W - OFFSET_W
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  recovery_PC_valid,
    output logic                  dram_req_valid,
    input  logic                  dram_req_ready,
    output logic [ADDR_WIDTH-1:0] dram_req_addr,
    input  logic                  dram_response_valid,
    input  logic [BLOCK_SIZE-1:0] dram_response,
    output logic                  fill_we,
    output logic [SET_W-1:0]      fill_set,
    output logic [WAY_W-1:0]      fill_way,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [BLOCK_SIZE-1:0] fill_data,
    output logic                  refill_busy
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]           perf_miss_cnt,
    output logic [31:0]           perf_drop_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_FILL} state_e;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFSET_W) - 1);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [SET_W-1:0]                 set_q;
    logic [TAG_W-1:0]                 tag_q;
    logic [WAY_W-1:0]                 way_q;
    logic [BLOCK_SIZE-1:0]            data_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]   rr_q;

    logic                             start_miss;
    logic                             take_resp;
    logic [SET_W-1:0]                 addr_set;
    logic [WAY_W-1:0]                 rr_cur;
    logic [WAY_W-1:0]                 rr_nxt;

    assign start_miss = (state_q == S_IDLE) && miss_valid && !recovery_PC_valid;
    assign take_resp  = (state_q == S_WAIT) && dram_response_valid && !recovery_PC_valid;
    assign addr_set   = addr_q[OFFSET_W +: SET_W];
    assign rr_cur     = rr_q[set_q];
    assign rr_nxt     = (rr_cur == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_aL) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_miss) state_d = S_REQ;
            S_REQ: begin
                if (dram_req_ready)         state_d = recovery_PC_valid ? S_DROP : S_WAIT;
                else if (recovery_PC_valid) state_d = S_IDLE;
            end
            S_WAIT: begin
                // A response coinciding with recovery is the one DROP would have waited for.
                if (recovery_PC_valid)        state_d = dram_response_valid ? S_IDLE : S_DROP;
                else if (dram_response_valid) state_d = S_FILL;
            end
            S_DROP: if (dram_response_valid) state_d = S_IDLE;
            S_FILL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dram_req_valid = (state_q == S_REQ);
        fill_we        = (state_q == S_FILL);
        refill_busy    = (state_q != S_IDLE);
    end

    // Fill fields are captured only on entry to FILL so they stay put at all other times.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            addr_q <= '0;
            set_q  <= '0;
            tag_q  <= '0;
            way_q  <= '0;
            data_q <= '0;
            rr_q   <= '0;
        end else begin
            if (start_miss) addr_q <= miss_addr & ALIGN_MASK;
            if (take_resp) begin
                data_q <= dram_response;
                set_q  <= addr_set;
                tag_q  <= addr_q[ADDR_WIDTH-1 -: TAG_W];
                way_q  <= rr_q[addr_set];
            end
            if (state_q == S_FILL) rr_q[set_q] <= rr_nxt;
        end
    end

    assign dram_req_addr = addr_q;
    assign fill_set      = set_q;
    assign fill_tag      = tag_q;
    assign fill_way      = way_q;
    assign fill_data     = data_q;

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] miss_cnt_q, drop_cnt_q;
    logic        drop_evt;

    assign drop_evt = recovery_PC_valid && ((state_q == S_REQ) || (state_q == S_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (start_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (drop_evt && (drop_cnt_q != '1))   drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign perf_miss_cnt = miss_cnt_q;
    assign perf_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: basic miss, backpressure, recovery, victim rotation, reset.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_aL;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        recovery_PC_valid;
    logic        dram_req_valid;
    logic        dram_req_ready;
    logic [31:0] dram_req_addr;
    logic        dram_response_valid;
    logic [63:0] dram_response;
    logic        fill_we;
    logic [5:0]  fill_set;
    logic [0:0]  fill_way;
    logic [22:0] fill_tag;
    logic [63:0] fill_data;
    logic        refill_busy;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_miss_cnt, perf_drop_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_req  = 0;
    int n_fill = 0;

    icache_refill_ctrl dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .miss_valid          (miss_valid),
        .miss_addr           (miss_addr),
        .recovery_PC_valid   (recovery_PC_valid),
        .dram_req_valid      (dram_req_valid),
        .dram_req_ready      (dram_req_ready),
        .dram_req_addr       (dram_req_addr),
        .dram_response_valid (dram_response_valid),
        .dram_response       (dram_response),
        .fill_we             (fill_we),
        .fill_set            (fill_set),
        .fill_way            (fill_way),
        .fill_tag            (fill_tag),
        .fill_data           (fill_data),
        .refill_busy         (refill_busy)
`ifdef ICACHE_REFILL_PERF_EN
        ,
        .perf_miss_cnt       (perf_miss_cnt),
        .perf_drop_cnt       (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_aL && dram_req_valid && dram_req_ready) n_req++;
        if (fill_we) n_fill++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full miss -> request -> response -> fill sequence, response 'lat' cycles after the request.
    task automatic refill(input string tg, input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [63:0] d, input int lat, input logic [5:0] es,
                          input logic [22:0] et, input logic ew);
        int f0;
        f0 = n_fill;
        miss_valid = 1'b1; miss_addr = a; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        chk({tg, ".req_v"},    dram_req_valid, 1);
        chk({tg, ".req_addr"}, dram_req_addr, exp_addr);
        repeat (lat) step();
        dram_response_valid = 1'b1; dram_response = d;
        step();
        dram_response_valid = 1'b0;
        chk({tg, ".we"},   fill_we, 1);
        chk({tg, ".set"},  fill_set, es);
        chk({tg, ".tag"},  fill_tag, et);
        chk({tg, ".way"},  fill_way, ew);
        chk({tg, ".data"}, fill_data, d);
        step();
        chk({tg, ".we_off"}, fill_we, 0);
        chk({tg, ".busy"},   refill_busy, 0);
        chk({tg, ".nfill"},  n_fill - f0, 1);
    endtask

    initial begin
        int r0, f0;
        rst_aL = 1'b0; miss_valid = 1'b0; miss_addr = '0; recovery_PC_valid = 1'b0;
        dram_req_ready = 1'b0; dram_response_valid = 1'b0; dram_response = '0;
        repeat (3) step();
        rst_aL = 1'b1;
        chk("rst.req_v", dram_req_valid, 0);
        chk("rst.busy",  refill_busy, 0);
        chk("rst.we",    fill_we, 0);
        chk("rst.addr",  dram_req_addr, 0);

        // 1. basic miss
        refill("basic", 32'h0000_1234, 32'h0000_1230, 64'hDEAD_BEEF_CAFE_F00D, 3, 6'h06, 23'h9, 1'b0);

        // 2. backpressure: same set again, so the second way is chosen
        r0 = n_req;
        miss_valid = 1'b1; miss_addr = 32'h0000_1234; dram_req_ready = 1'b0;
        step();
        miss_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp.req_v",    dram_req_valid, 1);
            chk("bp.req_addr", dram_req_addr, 32'h0000_1230);
            if (i < 3) step();
        end
        dram_req_ready = 1'b1;
        step();
        chk("bp.req_v_off", dram_req_valid, 0);
        chk("bp.nreq",      n_req - r0, 1);
        dram_response_valid = 1'b1; dram_response = 64'h1111_2222_3333_4444;
        step();
        dram_response_valid = 1'b0;
        chk("bp.we",  fill_we, 1);
        chk("bp.way", fill_way, 1);
        step();

        // 3. recovery while waiting for the response
        f0 = n_fill;
        miss_valid = 1'b1; miss_addr = 32'h0000_2000; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        step();
        recovery_PC_valid = 1'b1;
        step();
        recovery_PC_valid = 1'b0;
        chk("rw.busy_drop", refill_busy, 1);
        step();
        dram_response_valid = 1'b1; dram_response = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        dram_response_valid = 1'b0;
        chk("rw.busy", refill_busy, 0);
        chk("rw.we",   fill_we, 0);
        chk("rw.nfill", n_fill - f0, 0);
        refill("rw.new", 32'h0000_0080, 32'h0000_0080, 64'h0123_4567_89AB_CDEF, 1, 6'h10, 23'h0, 1'b0);

        // 4. recovery in REQ with no handshake
        r0 = n_req;
        miss_valid = 1'b1; miss_addr = 32'h0000_0300; dram_req_ready = 1'b0;
        step();
        miss_valid = 1'b0;
        chk("rr.req_v", dram_req_valid, 1);
        recovery_PC_valid = 1'b1;
        step();
        recovery_PC_valid = 1'b0;
        chk("rr.req_v_off", dram_req_valid, 0);
        chk("rr.busy",      refill_busy, 0);
        dram_req_ready = 1'b1;
        step();
        chk("rr.nreq", n_req - r0, 0);

        // both miss and recovery in IDLE: miss ignored
        miss_valid = 1'b1; recovery_PC_valid = 1'b1; miss_addr = 32'h0000_0500;
        step();
        miss_valid = 1'b0; recovery_PC_valid = 1'b0;
        chk("mr.busy", refill_busy, 0);

        // 5. victim rotation in set 8, independent pointer in set 9
        refill("v0", 32'h0000_0040, 32'h0000_0040, 64'hA0, 2, 6'h08, 23'h0, 1'b0);
        refill("v1", 32'h0000_0240, 32'h0000_0240, 64'hA1, 2, 6'h08, 23'h1, 1'b1);
        refill("v2", 32'h0000_0440, 32'h0000_0440, 64'hA2, 2, 6'h08, 23'h2, 1'b0);
        refill("v9", 32'h0000_0048, 32'h0000_0048, 64'hA9, 2, 6'h09, 23'h0, 1'b0);

        // 6. reset while in WAIT
        miss_valid = 1'b1; miss_addr = 32'h0000_1234; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        step();
        chk("rs.busy_wait", refill_busy, 1);
        rst_aL = 1'b0;
        step();
        rst_aL = 1'b1;
        chk("rs.busy",  refill_busy, 0);
        chk("rs.req_v", dram_req_valid, 0);
        chk("rs.addr",  dram_req_addr, 0);
        chk("rs.we",    fill_we, 0);
        chk("rs.set",   fill_set, 0);
        chk("rs.way",   fill_way, 0);
        chk("rs.tag",   fill_tag, 0);
        chk("rs.data",  fill_data, 0);
`ifdef ICACHE_REFILL_PERF_EN
        chk("rs.pmiss", perf_miss_cnt, 0);
        chk("rs.pdrop", perf_drop_cnt, 0);
`endif
        f0 = n_fill;
        dram_response_valid = 1'b1; dram_response = 64'hFFFF_0000_FFFF_0000;
        step();
        dram_response_valid = 1'b0;
        chk("rs.we_resp", fill_we, 0);
        step();
        chk("rs.nfill", n_fill - f0, 0);
        // set 8 pointer was at way 1; reset puts it back to way 0
        refill("rs.rr", 32'h0000_0040, 32'h0000_0040, 64'hB0, 1, 6'h08, 23'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
